// File: rtl/hsid_min_dist_sel.sv
// hsid_min_dist_sel
//
// Minimum-distance selector for one pixel search. It consumes the final
// accumulated distance for each library reference and keeps the smallest
// distance and the index of its reference. When every expected reference has
// been seen, it reports the result with a one-cycle done pulse.
//
// Optional feature macro: HSID_MAX_DIST_EN. When defined, the block also
// tracks the largest final distance and reports it on max_value / max_ref.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse that begins (or restarts) a search
//   library_size    number of references expected, sampled on start
//   acc_valid       distance beat valid
//   acc_value       accumulated distance (unsigned)
//   acc_last        beat carries the final distance of acc_ref
//   acc_ref         reference index of the beat
//   busy            search in progress
//   done            one-cycle pulse; results are valid in this cycle
//   min_value       smallest final distance (all ones when nothing was seen)
//   min_ref         reference index of min_value
//   error           sticky protocol error, cleared by start
//   max_value/ref   largest final distance and its index (HSID_MAX_DIST_EN)
module hsid_min_dist_sel #(
    parameter int DATA_WIDTH_ACC = 48,
    parameter int HSI_LIBRARY_SIZE = 4095,
    localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] library_size,
    input  logic                             acc_valid,
    input  logic [DATA_WIDTH_ACC-1:0]        acc_value,
    input  logic                             acc_last,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] acc_ref,
    output logic                             busy,
    output logic                             done,
    output logic [DATA_WIDTH_ACC-1:0]        min_value,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] min_ref,
    output logic                             error
`ifdef HSID_MAX_DIST_EN
    ,
    output logic [DATA_WIDTH_ACC-1:0]        max_value,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] max_ref
`endif
);

    // One extra counter bit so a full-size library never wraps the count.
    localparam int CNT_W = HSI_LIBRARY_SIZE_ADDR + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                           state;
    logic [HSI_LIBRARY_SIZE_ADDR-1:0] lib_size;
    logic [CNT_W-1:0]                 ref_cnt;
    logic [CNT_W-1:0]                 cnt_inc;
    logic                             last_beat;
    logic                             ref_in_range;
    logic                             final_ref;

    // Only final distances take part in the search; partial sums are ignored.
    assign last_beat    = acc_valid & acc_last;
    assign ref_in_range = acc_ref < lib_size;
    assign cnt_inc      = ref_cnt + CNT_W'(1);
    assign final_ref    = cnt_inc == {1'b0, lib_size};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            lib_size  <= '0;
            ref_cnt   <= '0;
            min_value <= '1;
            min_ref   <= '0;
            error     <= 1'b0;
`ifdef HSID_MAX_DIST_EN
            max_value <= '0;
            max_ref   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (start) begin
                // Start wins over any beat in the same cycle, in every state;
                // an aborted search simply reinitialises without a done pulse.
                lib_size  <= library_size;
                ref_cnt   <= '0;
                min_value <= '1;
                min_ref   <= '0;
                error     <= 1'b0;
`ifdef HSID_MAX_DIST_EN
                max_value <= '0;
                max_ref   <= '0;
`endif
                if (library_size == '0) begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (last_beat) begin
                            if (ref_in_range) begin
                                // Strict compare: ties keep the earlier winner.
                                if (acc_value < min_value) begin
                                    min_value <= acc_value;
                                    min_ref   <= acc_ref;
                                end
`ifdef HSID_MAX_DIST_EN
                                if (acc_value > max_value) begin
                                    max_value <= acc_value;
                                    max_ref   <= acc_ref;
                                end
`endif
                                ref_cnt <= cnt_inc;
                                if (final_ref) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        if (last_beat) error <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        if (last_beat) error <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hsid_min_dist_sel.sv
module tb_hsid_min_dist_sel;

    localparam int DW = 48;
    localparam int AW = 12;
    localparam logic [63:0] ONES = 64'h0000_FFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] library_size;
    logic          acc_valid;
    logic [DW-1:0] acc_value;
    logic          acc_last;
    logic [AW-1:0] acc_ref;
    logic          busy;
    logic          done;
    logic [DW-1:0] min_value;
    logic [AW-1:0] min_ref;
    logic          error;
`ifdef HSID_MAX_DIST_EN
    logic [DW-1:0] max_value;
    logic [AW-1:0] max_ref;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hsid_min_dist_sel #(
        .DATA_WIDTH_ACC(DW),
        .HSI_LIBRARY_SIZE(4095)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .library_size(library_size),
        .acc_valid(acc_valid),
        .acc_value(acc_value),
        .acc_last(acc_last),
        .acc_ref(acc_ref),
        .busy(busy),
        .done(done),
        .min_value(min_value),
        .min_ref(min_ref),
        .error(error)
`ifdef HSID_MAX_DIST_EN
        ,
        .max_value(max_value),
        .max_ref(max_ref)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        start     = 1'b0;
        acc_valid = 1'b0;
        acc_last  = 1'b0;
        acc_value = '0;
        acc_ref   = '0;
    endtask

    task automatic do_start(input int lib);
        clear_in();
        start        = 1'b1;
        library_size = lib[AW-1:0];
        step();
        start = 1'b0;
    endtask

    task automatic beat(input logic last, input int r, input logic [DW-1:0] v);
        clear_in();
        acc_valid = 1'b1;
        acc_last  = last;
        acc_ref   = r[AW-1:0];
        acc_value = v;
        step();
        clear_in();
    endtask

    // Reference model state for the randomized searches
    logic [DW-1:0] arr[$];
    int            refs[$];
    logic [DW-1:0] mq[$];
    int            iq[$];
    logic [DW-1:0] exp_min;
    int            exp_ref;
    int            ord[8];
    int            n, tmp, j;
    logic          inj;
    logic [DW-1:0] v;

    initial begin
        rst = 1'b1;
        library_size = '0;
        clear_in();
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_min", min_value, ONES);
        chk("rst_ref", min_ref, 0);
        chk("rst_err", error, 0);
        rst = 1'b0;
        step();

        // Basic search
        do_start(3);
        chk("b_busy", busy, 1);
        beat(1, 0, 100);
        beat(1, 1, 40);
        chk("b_mid_done", done, 0);
        beat(1, 2, 70);
        chk("b_done", done, 1);
        chk("b_busy0", busy, 0);
        chk("b_min", min_value, 40);
        chk("b_ref", min_ref, 1);
        chk("b_err", error, 0);
        step();
        chk("b_pulse", done, 0);
        chk("b_hold", min_value, 40);

        // Tie keeps the earlier winner
        do_start(2);
        beat(1, 0, 55);
        beat(1, 1, 55);
        chk("t_done", done, 1);
        chk("t_min", min_value, 55);
        chk("t_ref", min_ref, 0);
        step();

        // Empty library
        do_start(0);
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        chk("z_min", min_value, ONES);
        chk("z_ref", min_ref, 0);
        step();
        chk("z_done2", done, 0);
        chk("z_busy2", busy, 0);

        // Partial sums are never selected
        do_start(2);
        beat(0, 0, 5);
        beat(1, 0, 20);
        beat(0, 1, 5);
        chk("p_nodone", done, 0);
        beat(1, 1, 30);
        chk("p_done", done, 1);
        chk("p_min", min_value, 20);
        chk("p_ref", min_ref, 0);
        step();

        // Last beat in IDLE is a protocol error, cleared by start
        beat(1, 0, 1);
        chk("i_err", error, 1);
        chk("i_min", min_value, 20);
        do_start(1);
        chk("i_errclr", error, 0);
        beat(1, 0, 7);
        chk("i_done", done, 1);
        step();

        // Abort by restart: only one done pulse
        do_start(4);
        beat(1, 0, 3);
        beat(1, 1, 2);
        do_start(1);
        chk("a_nodone", done, 0);
        chk("a_busy", busy, 1);
        chk("a_min_init", min_value, ONES);
        beat(1, 0, 9);
        chk("a_done", done, 1);
        chk("a_min", min_value, 9);
        chk("a_ref", min_ref, 0);
        step();

        // Reset mid-search
        do_start(3);
        beat(1, 0, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("r_busy", busy, 0);
        chk("r_done", done, 0);
        chk("r_min", min_value, ONES);
        beat(1, 1, 4);
        chk("r_done2", done, 0);
        chk("r_err", error, 1);

        // Start together with a beat: the beat is dropped
        clear_in();
        start = 1'b1; library_size = 12'd1;
        acc_valid = 1'b1; acc_last = 1'b1; acc_ref = '0; acc_value = 48'd1;
        step();
        clear_in();
        chk("s_nodone", done, 0);
        chk("s_min", min_value, ONES);
        beat(1, 0, 88);
        chk("s_done", done, 1);
        chk("s_val", min_value, 88);
        step();

`ifdef HSID_MAX_DIST_EN
        do_start(3);
        beat(1, 0, 10);
        beat(1, 1, 300);
        beat(1, 2, 300);
        chk("x_done", done, 1);
        chk("x_max", max_value, 300);
        chk("x_mref", max_ref, 1);
        chk("x_min", min_value, 10);
        chk("x_ref", min_ref, 0);
        step();
`endif

        // Randomized searches against the model
        for (int s = 0; s < 30; s++) begin
            n   = $urandom_range(1, 8);
            inj = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 8; i++) ord[i] = i;
            for (int i = n - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
            end
            arr.delete();
            refs.delete();
            do_start(n);
            chk("rnd_busy", busy, 1);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 2) == 0) beat(0, ord[k], 48'd0);
                if (inj && k == 0) beat(1, n + $urandom_range(0, 3), 48'd0);
                if ($urandom_range(0, 1) == 1)
                    v = DW'($urandom_range(0, 7));
                else
                    v = {16'($urandom_range(0, 65534)), 32'($urandom)};
                arr.push_back(v);
                refs.push_back(ord[k]);
                beat(1, ord[k], v);
                if (k < n - 1) chk("rnd_early", done, 0);
            end
            mq = arr.min();
            exp_min = mq[0];
            iq = arr.find_first_index(x) with (x == exp_min);
            exp_ref = refs[iq[0]];
            chk("rnd_done", done, 1);
            chk("rnd_busy0", busy, 0);
            chk("rnd_min", min_value, exp_min);
            chk("rnd_ref", min_ref, exp_ref);
            chk("rnd_err", error, inj);
`ifdef HSID_MAX_DIST_EN
            mq = arr.max();
            iq = arr.find_first_index(x) with (x == mq[0]);
            chk("rnd_max", max_value, mq[0]);
            chk("rnd_mref", max_ref, (mq[0] == 0) ? 0 : refs[iq[0]]);
`endif
            // Odd iterations restart straight from the done cycle
            if (s % 2 == 0) begin
                step();
                chk("rnd_pulse", done, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
